// File: rtl/text_cursor_writer.sv
// Character RAM write-port driver: turns accepted character codes into RAM writes and cursor moves.
// Latency: a character write appears on we/w_row/w_col/din the cycle after its accept edge.
// Backpressure: in_ready is low for the whole of a row clear or full-screen clear, and high otherwise.
module text_cursor_writer #(
  parameter int         DATA_WIDTH = 8,
  parameter int         ROWS       = 4,
  parameter int         COLS       = 32,
  parameter logic [7:0] BLANK      = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    we,
  output logic [$clog2(ROWS)-1:0] w_row,
  output logic [$clog2(COLS)-1:0] w_col,
  output logic [DATA_WIDTH-1:0]   din,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic                    busy
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {S_IDLE, S_CLR_ROW, S_CLR_ALL} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_rdy;
  logic                  r_we, w_we_nxt;
  logic [RW-1:0]         r_w_row, w_w_row_nxt;
  logic [CW-1:0]         r_w_col, w_w_col_nxt;
  logic [DATA_WIDTH-1:0] r_din, w_din_nxt;
  logic [RW-1:0]         r_cur_row, w_cur_row_nxt;
  logic [CW-1:0]         r_cur_col, w_cur_col_nxt;
  // Clear counter: column walks every clear, row only advances in a full clear.
  logic [RW-1:0]         r_ctr_row, w_ctr_row_nxt;
  logic [CW-1:0]         r_ctr_col, w_ctr_col_nxt;

  logic                  w_is_print, w_is_lf, w_is_cr, w_is_bs, w_is_ff;
  logic                  w_cur_col_last, w_ctr_col_last, w_ctr_row_last;
  logic [RW-1:0]         w_cur_row_inc;

  assign w_is_print     = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign w_is_lf        = (in_data == 8'h0A);
  assign w_is_cr        = (in_data == 8'h0D);
  assign w_is_bs        = (in_data == 8'h08);
  assign w_is_ff        = (in_data == 8'h0C);
  // Wrap by explicit compare so non-power-of-2 geometries stay in range.
  assign w_cur_col_last = (r_cur_col == CW'(COLS - 1));
  assign w_ctr_col_last = (r_ctr_col == CW'(COLS - 1));
  assign w_ctr_row_last = (r_ctr_row == RW'(ROWS - 1));
  assign w_cur_row_inc  = (r_cur_row == RW'(ROWS - 1)) ? '0 : r_cur_row + RW'(1);

  // State register; reset lands in a full clear because the RAM itself has no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CLR_ALL;
    else        r_state <= w_state_nxt;
  end

  // Next-state: newline and end-of-row wrap clear the new row, form-feed clears everything.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if ((w_is_print && w_cur_col_last) || w_is_lf) w_state_nxt = S_CLR_ROW;
          else if (w_is_ff)                             w_state_nxt = S_CLR_ALL;
        end
      end
      S_CLR_ROW: if (w_ctr_col_last)                   w_state_nxt = S_IDLE;
      S_CLR_ALL: if (w_ctr_col_last && w_ctr_row_last) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values: write command, cursor and clear counter.
  always_comb begin
    w_we_nxt      = 1'b0;
    w_w_row_nxt   = r_w_row;
    w_w_col_nxt   = r_w_col;
    w_din_nxt     = r_din;
    w_cur_row_nxt = r_cur_row;
    w_cur_col_nxt = r_cur_col;
    w_ctr_row_nxt = r_ctr_row;
    w_ctr_col_nxt = r_ctr_col;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_is_print) begin
            w_we_nxt    = 1'b1;
            w_w_row_nxt = r_cur_row;
            w_w_col_nxt = r_cur_col;
            w_din_nxt   = DATA_WIDTH'(in_data);
            if (!w_cur_col_last) begin
              w_cur_col_nxt = r_cur_col + CW'(1);
            end else begin
              w_cur_col_nxt = '0;
              w_cur_row_nxt = w_cur_row_inc;
              w_ctr_row_nxt = w_cur_row_inc;
              w_ctr_col_nxt = '0;
            end
          end else if (w_is_lf) begin
            w_cur_col_nxt = '0;
            w_cur_row_nxt = w_cur_row_inc;
            w_ctr_row_nxt = w_cur_row_inc;
            w_ctr_col_nxt = '0;
          end else if (w_is_cr) begin
            w_cur_col_nxt = '0;
          end else if (w_is_bs) begin
            // Backspace never wraps back onto the previous row.
            if (r_cur_col != '0) begin
              w_cur_col_nxt = r_cur_col - CW'(1);
              w_we_nxt      = 1'b1;
              w_w_row_nxt   = r_cur_row;
              w_w_col_nxt   = r_cur_col - CW'(1);
              w_din_nxt     = DATA_WIDTH'(BLANK);
            end
          end else if (w_is_ff) begin
            w_cur_row_nxt = '0;
            w_cur_col_nxt = '0;
            w_ctr_row_nxt = '0;
            w_ctr_col_nxt = '0;
          end
        end
      end
      S_CLR_ROW, S_CLR_ALL: begin
        w_we_nxt      = 1'b1;
        w_w_row_nxt   = r_ctr_row;
        w_w_col_nxt   = r_ctr_col;
        w_din_nxt     = DATA_WIDTH'(BLANK);
        w_ctr_col_nxt = w_ctr_col_last ? '0 : r_ctr_col + CW'(1);
        if ((r_state == S_CLR_ALL) && w_ctr_col_last) begin
          w_ctr_row_nxt = w_ctr_row_last ? '0 : r_ctr_row + RW'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and cursor; ready is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy     <= 1'b0;
      r_we      <= 1'b0;
      r_w_row   <= '0;
      r_w_col   <= '0;
      r_din     <= '0;
      r_cur_row <= '0;
      r_cur_col <= '0;
      r_ctr_row <= '0;
      r_ctr_col <= '0;
    end else begin
      r_rdy     <= (w_state_nxt == S_IDLE);
      r_we      <= w_we_nxt;
      r_w_row   <= w_w_row_nxt;
      r_w_col   <= w_w_col_nxt;
      r_din     <= w_din_nxt;
      r_cur_row <= w_cur_row_nxt;
      r_cur_col <= w_cur_col_nxt;
      r_ctr_row <= w_ctr_row_nxt;
      r_ctr_col <= w_ctr_col_nxt;
    end
  end

  assign in_ready = r_rdy;
  assign busy     = ~r_rdy;
  assign we       = r_we;
  assign w_row    = r_w_row;
  assign w_col    = r_w_col;
  assign din      = r_din;
  assign cur_row  = r_cur_row;
  assign cur_col  = r_cur_col;

endmodule

// File: tb/tb_text_cursor_writer.sv
// Bench for text_cursor_writer: directed scenarios then random traffic against a queue-based model.
module tb_text_cursor_writer;

  localparam int ROWS  = 4;
  localparam int COLS  = 32;
  localparam int BLANK = 8'h20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, we, busy;
  logic [1:0] w_row, cur_row;
  logic [4:0] w_col, cur_col;
  logic [7:0] din;

  int n_chk  = 0;
  int n_fail = 0;

  text_cursor_writer #(.DATA_WIDTH(8), .ROWS(ROWS), .COLS(COLS), .BLANK(8'h20)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .we(we), .w_row(w_row), .w_col(w_col), .din(din), .cur_row(cur_row), .cur_col(cur_col),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: cursor plus a queue of pending blank writes; ready means the queue is empty.
  int m_row, m_col;
  int cq_r[$];
  int cq_c[$];
  bit e_we;
  int e_r, e_c, e_d;

  function automatic void push_row(int r);
    for (int c = 0; c < COLS; c++) begin
      cq_r.push_back(r);
      cq_c.push_back(c);
    end
  endfunction

  function automatic void m_reset();
    m_row = 0; m_col = 0;
    cq_r.delete(); cq_c.delete();
    for (int r = 0; r < ROWS; r++) push_row(r);
    e_we = 1'b0; e_r = 0; e_c = 0; e_d = 0;
  endfunction

  // One clock edge of the model; returns whether the presented code was accepted.
  function automatic bit m_edge(bit v, int d);
    bit acc;
    acc  = 1'b0;
    e_we = 1'b0;
    if (cq_r.size() > 0) begin
      e_we = 1'b1; e_r = cq_r.pop_front(); e_c = cq_c.pop_front(); e_d = BLANK;
    end else if (v) begin
      acc = 1'b1;
      if (d >= 8'h20 && d <= 8'h7E) begin
        e_we = 1'b1; e_r = m_row; e_c = m_col; e_d = d;
        if (m_col < COLS - 1) m_col++;
        else begin
          m_col = 0; m_row = (m_row + 1) % ROWS; push_row(m_row);
        end
      end else if (d == 8'h0A) begin
        m_col = 0; m_row = (m_row + 1) % ROWS; push_row(m_row);
      end else if (d == 8'h0D) begin
        m_col = 0;
      end else if (d == 8'h08) begin
        if (m_col > 0) begin
          m_col--;
          e_we = 1'b1; e_r = m_row; e_c = m_col; e_d = BLANK;
        end
      end else if (d == 8'h0C) begin
        m_row = 0; m_col = 0;
        for (int r = 0; r < ROWS; r++) push_row(r);
      end
    end
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_wrow"}, 32'(w_row), 0);
    chk({tag, "_wcol"}, 32'(w_col), 0);
    chk({tag, "_din"}, 32'(din), 0);
    chk({tag, "_crow"}, 32'(cur_row), 0);
    chk({tag, "_ccol"}, 32'(cur_col), 0);
    chk({tag, "_rdy"}, 32'(in_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
  endtask

  // Advance one edge with the inputs currently driven, then compare every output to the model.
  task automatic step(output bit acc);
    bit v;
    int d;
    v = in_valid;
    d = in_data;
    @(posedge clk);
    acc = m_edge(v, d);
    #1;
    chk("we", 32'(we), 32'(e_we));
    if (e_we) begin
      chk("w_row", 32'(w_row), 32'(e_r));
      chk("w_col", 32'(w_col), 32'(e_c));
      chk("din", 32'(din), 32'(e_d));
    end
    chk("cur_row", 32'(cur_row), 32'(m_row));
    chk("cur_col", 32'(cur_col), 32'(m_col));
    chk("in_ready", 32'(in_ready), 32'(cq_r.size() == 0));
    chk("busy", 32'(busy), 32'(cq_r.size() != 0));
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  // Hold a code valid until the model accepts it, with a bounded wait.
  task automatic send(input logic [7:0] c);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = c;
    while (!acc && n < 400) begin
      step(acc);
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int r;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    m_reset();
    #2;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Power-up clear with in_valid held high: nothing may be accepted during it.
    in_valid = 1'b1; in_data = 8'h41;
    for (int i = 0; i < ROWS * COLS; i++) step(acc);
    in_valid = 1'b0;
    idle(2);

    // Two characters on consecutive edges.
    send(8'h48); send(8'h49);
    idle(1);

    // Fill row 0 to trigger end-of-row wrap and row-1 clear while valid stays high.
    send(8'h0D);
    for (int i = 0; i < COLS; i++) send(8'h41);
    in_valid = 1'b1; in_data = 8'h42;
    for (int i = 0; i < COLS; i++) step(acc);
    in_valid = 1'b0;
    idle(1);

    // Backspace mid-row and at column 0.
    send(8'h48); send(8'h49); send(8'h08);
    send(8'h0D); send(8'h08);
    idle(2);

    // Newline wrap from row 3 to row 0, CR mid-row, dropped control code.
    send(8'h0A); send(8'h0A); send(8'h0A);
    send(8'h0A); send(8'h0A); send(8'h0A);
    for (int i = 0; i < 7; i++) send(8'h61 + 8'(i));
    send(8'h0D); send(8'h07); send(8'h7F); send(8'h00);
    idle(2);

    // Reset in the middle of a row clear, then the full clear restarts.
    send(8'h0A);
    idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    m_reset();
    @(posedge clk); @(posedge clk);
    #1;
    chk_reset_vals("rsthold");
    @(negedge clk);
    rst_n = 1'b1;
    idle(ROWS * COLS + 2);

    // Form-feed from a non-zero cursor.
    send(8'h0A); idle(COLS); send(8'h5A);
    send(8'h0C);
    idle(ROWS * COLS + 2);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      in_valid = ($urandom_range(0, 99) < 65);
      r = $urandom_range(0, 199);
      if      (r < 120) in_data = 8'($urandom_range(32, 126));
      else if (r < 135) in_data = 8'h0A;
      else if (r < 150) in_data = 8'h0D;
      else if (r < 180) in_data = 8'h08;
      else if (r < 182) in_data = 8'h0C;
      else              in_data = 8'($urandom_range(0, 255));
      step(acc);
    end
    idle(ROWS * COLS + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
